// File: rtl/blind_spot_multi.sv
// Two-sided blind-spot monitor: debounced per-side presence FSMs with post-clear hold,
// plus a shared blink generator that flashes a warning when turning toward an occupied side.
module blind_spot_multi #(
  parameter int ZONES      = 2,
  parameter int DEBOUNCE   = 3,
  parameter int HOLD       = 4,
  parameter int BLINK_HALF = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enable,
  input  logic [ZONES-1:0] right_side,
  input  logic [ZONES-1:0] left_side,
  input  logic             turn_right,
  input  logic             turn_left,
  output logic [1:0]       blind,
  output logic [1:0]       warn
);

  localparam int MAXC = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = (HOLD > 0) ? CW'(HOLD - 1) : '0;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Index 0 is the right side, index 1 the left side, matching the output bit order.
  state_e          state_q [2];
  state_e          state_d [2];
  logic [CW-1:0]   cnt_q   [2];
  logic [CW-1:0]   cnt_d   [2];
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic [1:0]      blind_q, blind_d;
  logic [1:0]      warn_q, warn_d;
  logic [1:0]      det;
  logic [1:0]      turn;
  logic [1:0]      cond;

  assign det  = {|left_side, |right_side};
  assign turn = {turn_left, turn_right};
  assign cond = blind_q & turn;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= ST_CLEAR;
        cnt_q[s]   <= '0;
      end
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      blind_q <= 2'b00;
      warn_q  <= 2'b00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      blind_q <= blind_d;
      warn_q  <= warn_d;
    end
  end

  // Next-state logic for both per-side FSMs
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      if (!enable) begin
        state_d[s] = ST_CLEAR;
        cnt_d[s]   = '0;
      end else begin
        case (state_q[s])
          ST_CLEAR: begin
            if (det[s]) begin
              if (DEBOUNCE == 1) begin
                state_d[s] = ST_ACTIVE;
                cnt_d[s]   = '0;
              end else begin
                state_d[s] = ST_PENDING;
                cnt_d[s]   = CW'(1);
              end
            end
          end
          ST_PENDING: begin
            if (!det[s]) begin
              state_d[s] = ST_CLEAR;
              cnt_d[s]   = '0;
            end else if (cnt_q[s] == DEB_LAST) begin
              state_d[s] = ST_ACTIVE;
              cnt_d[s]   = '0;
            end else begin
              cnt_d[s] = cnt_q[s] + CW'(1);
            end
          end
          ST_ACTIVE: begin
            if (!det[s]) begin
              state_d[s] = (HOLD == 0) ? ST_CLEAR : ST_HOLD;
              cnt_d[s]   = '0;
            end
          end
          ST_HOLD: begin
            if (det[s]) begin
              state_d[s] = ST_ACTIVE;
              cnt_d[s]   = '0;
            end else if (cnt_q[s] == HOLD_LAST) begin
              state_d[s] = ST_CLEAR;
              cnt_d[s]   = '0;
            end else begin
              cnt_d[s] = cnt_q[s] + CW'(1);
            end
          end
          default: begin
            state_d[s] = ST_CLEAR;
            cnt_d[s]   = '0;
          end
        endcase
      end
    end
  end

  // Output logic: indicators from next state, shared blink phase, warnings
  always_comb begin
    blind_d = 2'b00;
    for (int s = 0; s < 2; s++) begin
      blind_d[s] = (state_d[s] == ST_ACTIVE) || (state_d[s] == ST_HOLD);
    end

    bcnt_d  = '0;
    phase_d = 1'b1;
    if (enable && (cond != 2'b00)) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
      end
    end

    warn_d = enable ? (cond & {2{phase_q}}) : 2'b00;
  end

  assign blind = blind_q;
  assign warn  = warn_q;

endmodule

// File: tb/tb_blind_spot_multi.sv
// Directed bench for blind_spot_multi (ZONES=2, DEBOUNCE=3, HOLD=4, BLINK_HALF=2).
module tb_blind_spot_multi;

  logic       CLK;
  logic       RST_N;
  logic       enable;
  logic [1:0] right_side;
  logic [1:0] left_side;
  logic       turn_right;
  logic       turn_left;
  logic [1:0] blind;
  logic [1:0] warn;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  blind_spot_multi #(
    .ZONES(2), .DEBOUNCE(3), .HOLD(4), .BLINK_HALF(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .right_side(right_side), .left_side(left_side),
    .turn_right(turn_right), .turn_left(turn_left),
    .blind(blind), .warn(warn)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one active edge and settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; enable = 1'b0;
    right_side = 2'b00; left_side = 2'b00;
    turn_right = 1'b0; turn_left = 1'b0;
    #2;
    check("reset_blind", blind, 2'b00);
    check("reset_warn", warn, 2'b00);
    tick(); tick();
    RST_N = 1'b1; enable = 1'b1;
    tick();

    // Debounce glitch: two samples then a drop never lights
    right_side = 2'b01;
    tick(); check("glitch_e1", blind, 2'b00);
    tick(); check("glitch_e2", blind, 2'b00);
    right_side = 2'b00;
    tick(); check("glitch_drop", blind, 2'b00);
    tick();

    // Three consecutive samples light the right indicator
    right_side = 2'b10;
    tick(); check("deb_e1", blind, 2'b00);
    tick(); check("deb_e2", blind, 2'b00);
    tick(); check("deb_e3", blind, 2'b01);

    // Warning blink sequence toward the occupied right side
    check("warn_before", warn, 2'b00);
    turn_right = 1'b1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    while (exp_q.size() > 0) begin
      tick();
      check("warn_blink", warn, exp_q.pop_front());
    end
    turn_right = 1'b0;
    tick(); check("warn_off", warn, 2'b00);

    // Turning toward an empty side never warns
    turn_left = 1'b1;
    tick(); check("warn_left_empty1", warn, 2'b00);
    tick(); check("warn_left_empty2", warn, 2'b00);
    turn_left = 1'b0;

    // Clear right: HOLD=4 cycles then off
    right_side = 2'b00;
    repeat (4) tick();
    check("right_hold_end", blind, 2'b01);
    tick(); check("right_cleared", blind, 2'b00);

    // Left hold timing
    left_side = 2'b01;
    repeat (3) tick();
    check("left_active", blind, 2'b10);
    left_side = 2'b00;
    tick(); check("hold_j", blind, 2'b10);
    tick(); check("hold_j1", blind, 2'b10);
    tick(); check("hold_j2", blind, 2'b10);
    tick(); check("hold_j3", blind, 2'b10);
    tick(); check("hold_j4", blind, 2'b00);

    // Re-detect during hold keeps the indicator lit without a gap
    left_side = 2'b10;
    repeat (3) tick();
    check("left_active2", blind, 2'b10);
    left_side = 2'b00;
    tick(); check("retrig_j", blind, 2'b10);
    tick(); check("retrig_j1", blind, 2'b10);
    left_side = 2'b01;
    tick(); check("retrig_j2", blind, 2'b10);
    tick(); check("retrig_j3", blind, 2'b10);
    tick(); check("retrig_j4", blind, 2'b10);
    tick(); check("retrig_j5", blind, 2'b10);
    left_side = 2'b00;
    repeat (5) tick();
    check("left_cleared", blind, 2'b00);

    // Simultaneous rise on both sides
    right_side = 2'b11; left_side = 2'b01;
    tick(); check("sim_e1", blind, 2'b00);
    tick(); check("sim_e2", blind, 2'b00);
    tick(); check("sim_e3", blind, 2'b11);

    // Asynchronous reset mid-cycle while lit and warning
    turn_right = 1'b1;
    tick();
    check("pre_reset_blind", blind, 2'b11);
    check("pre_reset_warn", warn, 2'b01);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_blind", blind, 2'b00);
    check("async_rst_warn", warn, 2'b00);
    RST_N = 1'b1;

    // Relight after reset, then enter HOLD with the warning active
    tick(); tick();
    check("post_rst_e2", blind, 2'b00);
    tick(); check("post_rst_e3", blind, 2'b11);
    tick(); check("post_rst_warn", warn, 2'b01);
    right_side = 2'b00;
    tick();
    check("hold_warn_blind", blind, 2'b11);
    check("hold_warn_warn", warn, 2'b01);

    // One disabled edge clears everything; relight needs fresh samples
    enable = 1'b0;
    tick();
    check("dis_blind", blind, 2'b00);
    check("dis_warn", warn, 2'b00);
    enable = 1'b1; right_side = 2'b01;
    tick(); check("reen_e1", blind, 2'b00);
    tick(); check("reen_e2", blind, 2'b00);
    tick(); check("reen_e3", blind, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blind_spot_multi.md
# blind_spot_multi

Parametrised blind-spot monitor for the body control module. Watches ZONES presence sensors per side, debounces detections, and holds the side-mirror indicator on for a programmable time after the zone clears. When the driver signals a turn toward an occupied side, it drives a flashing warning. It replaces the single-sensor, unfiltered monitor and feeds the mirror-lamp drivers.

## Interface
- ZONES, 2: presence sensors per side, ≥1.
- DEBOUNCE, 3: consecutive detect samples before the indicator lights, ≥1.
- HOLD, 4: cycles the indicator stays lit after detection drops, ≥0.
- BLINK_HALF, 2: cycles per warning half-period (on, then off), ≥1.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low; one clock, no other reset.
- enable  in  1  monitor enable; low forces everything idle (synchronous).
- right_side  in  ZONES  right sensors, 1 = object present.
- left_side  in  ZONES  left sensors, 1 = object present.
- turn_right  in  1  right turn signal active.
- turn_left  in  1  left turn signal active.
- blind  out  2  mirror indicators: bit0 = right, bit1 = left (00 off, 01 right, 10 left, 11 both); registered.
- warn  out  2  flashing turn-conflict warning: bit0 = right, bit1 = left; registered.

## Operation
- Per-side detect: det_r = OR of right_side, det_l = OR of left_side. Inputs are synchronous to CLK.
- Two independent, identical per-side FSMs (right drives blind[0], left drives blind[1]). Each has its own counter, width $clog2(max(DEBOUNCE,HOLD)+1).
- CLEAR (blind bit 0):
  - det=1 → PENDING with cnt=1.
  - If DEBOUNCE==1, det=1 → ACTIVE directly.
- PENDING (bit 0):
  - det=0 → CLEAR.
  - det=1 and cnt==DEBOUNCE-1 → ACTIVE.
  - Otherwise cnt++.
- ACTIVE (bit 1): det=0 → HOLD with cnt=0 (→ CLEAR directly if HOLD==0).
- HOLD (bit 1):
  - det=1 → ACTIVE, no re-debounce.
  - det=0 and cnt==HOLD-1 → CLEAR.
  - Otherwise cnt++.
- blind bit = 1 exactly in ACTIVE or HOLD.
- Both sides are fully independent. Simultaneous events on both sides are processed in the same cycle, so blind may go 00→11 in one edge.
- Warning condition per side: cond_s = blind[s] & turn_s.
- Blink generator, shared by both sides: blink counter, width $clog2(BLINK_HALF), plus a phase bit.
  - If neither cond_s is true: counter←0, phase←1.
  - Else: counter++; when counter==BLINK_HALF-1, counter←0 and phase toggles.
- warn[s] ← cond_s & phase, using the pre-edge values of blind, turn and phase.
- Both sides share the phase, so warnings on both sides flash in unison.
- enable=0 at an edge: both FSMs → CLEAR, counters 0, blink counter 0, phase 1, blind←00, warn←00. Sensors are ignored while enable is low. Counting restarts from CLEAR once enable returns to 1.

## Timing
- Reset (RST_N low, asynchronous): FSMs CLEAR, all counters 0, phase 1, blind=00, warn=00. Outputs change immediately, without waiting for a clock.
- Reset release: the first active edge is the first CLK rise with RST_N high.
- Assert latency: det sampled 1 at edges k … k+DEBOUNCE-1 → blind bit 1 after edge k+DEBOUNCE-1. A single 0 sample inside that window restarts the count.
- Release latency: first det=0 sample at edge j → blind bit 0 after edge j+HOLD, provided det stays 0. Any det=1 during HOLD returns to ACTIVE with no gap.
- Warn latency: cond_s first true before edge e → warn[s]=1 after e.
  - warn[s] stays high BLINK_HALF cycles, then low BLINK_HALF cycles, repeating while cond_s holds.
  - cond_s false before edge f → warn[s]=0 after f.
- Counters never wrap; every count is bounded by its compare value.
- RST_N asserted mid-operation (PENDING/HOLD/blinking) → immediate return to the reset values.

## Test plan
All scenarios use ZONES=2, DEBOUNCE=3, HOLD=4, BLINK_HALF=2.
- Reset: RST_N=0 mid-cycle while blind=11 and warn=01 → blind=00 and warn=00 immediately, without waiting for a clock.
- Debounce:
  - right_side=01 for 2 edges, then 00 → blind stays 00.
  - right_side=10 for 3 edges → blind=01 after the 3rd edge.
- Hold:
  - left ACTIVE, left_side→00 at edge j → blind=10 through edge j+3, 00 after j+4.
  - Same, but left_side=01 at edge j+2 → blind stays 10 continuously.
- Simultaneous: right_side=11 and left_side=01 rising together for 3 edges → blind 00→11 at the same edge.
- Warning:
  - blind=01, turn_right=1 from edge e → warn sequence 01,01,00,00,01,01… starting after e.
  - turn_right=0 → warn=00 next edge.
  - turn_left=1 while blind[1]=0 → warn[1] stays 0.
- Enable: enable=0 for one edge while in HOLD with warn active → blind=00, warn=00 after that edge. Afterwards, with enable=1 and det held high, relighting requires 3 fresh samples.
